// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared types, widths and frame classifier for the keypad scanner
package keypad_scanner_pkg;
  localparam int KEY_CODE_W = 4;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } frame_cls_t;
  typedef struct packed {
    frame_cls_t            cls;
    logic [KEY_CODE_W-1:0] code;
  } frame_info_t;
  // Frame bit index is row*4+col, so the index of a lone set bit is the key code.
  function automatic frame_info_t classify(input logic [15:0] f);
    frame_info_t r;
    int n;
    r.code = '0;
    n = 0;
    for (int i = 0; i < 16; i++)
      if (f[i]) begin
        n++;
        r.code = KEY_CODE_W'(i);
      end
    r.cls = n == 0 ? CLS_NONE : n == 1 ? CLS_SINGLE : CLS_MULTI;
    return r;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key event valid/ready port plus pressed/overrun status
import keypad_scanner_pkg::*;
interface keypad_scanner_if;
  logic                  key_valid;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_ready;
  logic                  key_pressed;
  logic                  key_overrun;
  modport master(output key_valid, key_code, key_pressed, key_overrun, input key_ready);
  modport slave(input key_valid, key_code, key_pressed, key_overrun, output key_ready);
endinterface

// File: rtl/keypad_scanner_debounce.sv
// keypad_scanner_debounce: per-frame classification and press/release debounce FSM
import keypad_scanner_pkg::*;
module keypad_scanner_debounce #(
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [15:0]           frame_i,
  input  logic                  done_i,
  output logic                  emit_o,
  output logic [KEY_CODE_W-1:0] code_o,
  output logic                  pressed_o
);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic                  emit_q, emit_d;
  frame_info_t           info;
  assign info    = classify(frame_i);
  assign cnt_inc = cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1);
  assign emit_o  = emit_q;
  assign code_o  = cand_q;
  // State, frame counter, candidate code and registered emit strobe
  always_ff @(posedge clk)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      emit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      emit_q  <= emit_d;
    end
  // Next state, advanced only on a completed frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    emit_d  = 1'b0;
    if (done_i)
      case (state_q)
        IDLE:
          if (info.cls == CLS_SINGLE) begin
            cand_d  = info.code;
            cnt_d   = CW'(1);
            state_d = PRESS_DB;
          end
        PRESS_DB:
          if (info.cls == CLS_SINGLE && info.code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = HELD;
              emit_d  = 1'b1;
            end
          end else state_d = IDLE;
        HELD:
          if (info.cls == CLS_NONE) begin
            cnt_d   = CW'(1);
            state_d = RELEASE_DB;
          end
        default:
          if (info.cls == CLS_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) state_d = IDLE;
          end else state_d = HELD;
      endcase
  end
  // A key counts as held until its release has been debounced
  always_comb begin
    pressed_o = state_q == HELD || state_q == RELEASE_DB;
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, row sync, frame capture and one-entry key event register
import keypad_scanner_pkg::*;
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        keypad_row,
  output logic [3:0]        keypad_col,
  keypad_scanner_if.master  key_if
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [3:0]            sync1_q, sync2_q;
  logic [PW-1:0]         pre_q;
  logic [1:0]            col_q;
  logic [15:0]           frame_q, frame_d;
  logic                  done_q, tick, emit;
  logic [KEY_CODE_W-1:0] db_code, code_q;
  logic                  valid_q, overrun_q;
  assign tick       = pre_q == PW'(SCAN_DIV - 1);
  assign keypad_col = ~(4'b0001 << col_q);
  // Latch each row of the current column into its row*4+col frame bit on the tick
  always_comb begin
    frame_d = frame_q;
    for (int r = 0; r < 4; r++)
      if (tick) frame_d[{r[1:0], col_q}] = sync2_q[r];
  end
  // Synchronizer (inverted so 1 = pressed), prescaler, column index, frame and frame-done strobe
  always_ff @(posedge clk)
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= ~keypad_row;
      sync2_q <= sync1_q;
      pre_q   <= tick ? '0 : pre_q + PW'(1);
      col_q   <= col_q + 2'(tick);
      frame_q <= frame_d;
      done_q  <= tick && col_q == 2'd3;
    end
  keypad_scanner_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db (
    .clk      (clk),
    .rstn     (rstn),
    .frame_i  (frame_q),
    .done_i   (done_q),
    .emit_o   (emit),
    .code_o   (db_code),
    .pressed_o(key_if.key_pressed)
  );
  // Holding register: a new event replaces the old one only if the old one leaves this cycle
  always_ff @(posedge clk)
    if (!rstn) begin
      valid_q   <= 1'b0;
      code_q    <= '0;
      overrun_q <= 1'b0;
    end else if (emit) begin
      if (!valid_q || key_if.key_ready) begin
        valid_q   <= 1'b1;
        code_q    <= db_code;
        overrun_q <= 1'b0;
      end else overrun_q <= 1'b1;
    end else if (valid_q && key_if.key_ready) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  assign key_if.key_valid   = valid_q;
  assign key_if.key_code    = code_q;
  assign key_if.key_overrun = overrun_q;
endmodule
